clk_rate_monitor: RTL and testbench
===================================

# clk_rate_monitor

Multi-channel clock-rate monitor running entirely on the reference clock `clkref`. Each of NCH asynchronous toggle inputs, driven by a divide-by-2 flop in the measured clock's own domain, is synchronised and edge-counted over a fixed gate window. Results are latched without dead time between windows, read out through a channel-select port, and optionally checked against frequency limits. It is the multi-channel, full-precision successor to the single-channel rate counter in the clock-monitoring path.

## Interface
- `NCH`, 4: number of measured channels, 1..16.
- `CLKREF_RATE_IN_MHZ`, 100: rate of `clkref` in MHz.
- `RESULT_UNIT_HZ`, 100: frequency represented by one count.
  - Gate length W = CLKREF_RATE_IN_MHZ*1000000/RESULT_UNIT_HZ `clkref` cycles; W must be at least 4.
- `CNT_W`, 32: result and counter width.
- `SEL_W`, 4: width of `sel`; must satisfy 2^SEL_W ≥ NCH.
- `clkref`  in  1  only clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  measurement enable (level).
- `toggle_in`  in  NCH  asynchronous toggles, each equal to f_test/2.
- `sel`  in  SEL_W  readout channel select.
- `lo_limit`, `hi_limit`  in  CNT_W  alarm limits, shared by all channels.
- `value`  out  CNT_W  registered result of channel `sel`.
- `update`  out  1  one-cycle pulse when results refresh.
- `ovf`  out  NCH  per-channel counter saturated in last window.
- `alarm`  out  NCH  per-channel limit violation.
- `busy`  out  1  high while gating (state RUN).

## Operation
- Per channel, a three-flop chain (sync1, sync2, post) detects edges. An edge is counted when sync2 differs from post.
  - Both edges are counted, so one count equals one measured clock cycle. No ×2 correction is applied.
- Valid range: f_test ≤ 0.8 × f_clkref. Above this range, counts are undefined, but the block must not hang.
- FSM states:
  - IDLE: window counter = 0; edge counters held at 0; results retained.
  - RUN: window counter counts 0..W-1. On reaching W-1, the block performs the latch and the window counter wraps to 0 in the same cycle.
- IDLE→RUN when `enable`=1. RUN→IDLE when `enable`=0, from any window position. An aborted window produces no `update` and changes no result.
- Latch cycle, per channel:
  - result ← counter + edge_now, saturating.
  - counter ← 0. The next window starts in the following cycle, so no edge is lost or double-counted.
- Counter arithmetic saturates at 2^CNT_W-1 and sets a sticky per-window overflow bit. At latch, `ovf[i]` ← that bit and the bit is cleared.
- Readout: `value` ← result[`sel`] every cycle. If `sel` ≥ NCH, `value` ← 0.

## Timing
- Reset value of every output is 0. Every internal result, counter, sync flop and state register is also reset: state IDLE, results 0.
- A toggle edge is counted 3 `clkref` cycles after the flop input changes (synchroniser plus detect).
- Gate spacing: `update` pulses exactly every W cycles while `enable` stays high. The first pulse comes W cycles after the first RUN cycle.
- `update` is asserted in the cycle after the latch cycle, which is when the new results are visible.
  - `value` reflects the new result one cycle later (registered mux), or one cycle after any `sel` change.
- `ovf` and `alarm` change only in the same cycle as `update`.
- `enable` falling in the same cycle as the latch: the latch completes, `update` fires, then the block enters IDLE.
- Asynchronous `rst` mid-window: outputs clear immediately. RUN restarts a full window after `rst` is released, if `enable`=1.

## Configuration
- `CLK_RATE_MON_ALARM_EN` defined:
  - At latch, `alarm[i]` ← (result < `lo_limit`) | (result > `hi_limit`) | overflow.
  - Comparisons are unsigned and use the saturated result.
- Not defined: `alarm` is tied to 0, and `lo_limit`/`hi_limit` are ignored. Ports remain present.

## Test plan
Common parameters: CLKREF_RATE_IN_MHZ=100, RESULT_UNIT_HZ=100000 (W=1000), NCH=4, `enable`=1, unless a scenario overrides them.
- Steady rate: ch0 toggles every 4 cycles (25 MHz) and ch1 every 10 cycles (10 MHz) -> successive results are 250±1 and 100±1; `update` pulses exactly every 1000 cycles.
- Stuck clock, macro defined: ch2 held constant, `lo_limit`=1, `hi_limit`=300 -> ch2 result is 0 and `alarm[2]`=1; ch0 at 25 MHz gives `alarm[0]`=0.
- Saturation, CNT_W=8: ch0 toggles every 2 cycles -> result is 255 and `ovf[0]`=1. Toggle then slows to every 10 cycles -> the next window gives 100 and `ovf[0]`=0.
- Abort: `enable` dropped at window cycle 500 -> no `update`, results unchanged. Re-enable -> next `update` 1000 cycles later with a full-window count.
- Reset mid-run: `rst` pulsed at cycle 700 -> `value`, `ovf`, `alarm`, `update`, `busy` go to 0 immediately; the first post-reset result is correct.
- Readout: `sel`=1 -> `value`=100 one cycle later; `sel`=9 -> `value`=0.

Source files
------------

// File: rtl/clk_rate_monitor.sv
// clk_rate_monitor: multi-channel clock-rate monitor on the reference clock.
// Optional limit alarms are built when CLK_RATE_MON_ALARM_EN is defined.
module clk_rate_monitor #(
   parameter int NCH                = 4,
   parameter int CLKREF_RATE_IN_MHZ = 100,
   parameter int RESULT_UNIT_HZ     = 100,
   parameter int CNT_W              = 32,
   parameter int SEL_W              = 4
) (
   input  logic             clkref,
   input  logic             rst,
   input  logic             enable,
   input  logic [NCH-1:0]   toggle_in,
   input  logic [SEL_W-1:0] sel,
   input  logic [CNT_W-1:0] lo_limit,
   input  logic [CNT_W-1:0] hi_limit,
   output logic [CNT_W-1:0] value,
   output logic             update,
   output logic [NCH-1:0]   ovf,
   output logic [NCH-1:0]   alarm,
   output logic             busy
);

   localparam longint W =
      longint'(CLKREF_RATE_IN_MHZ) * 64'd1000000 / longint'(RESULT_UNIT_HZ);
   localparam int WC_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [WC_W-1:0] W_LAST = WC_W'(W - 1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic [WC_W-1:0]  r_wcnt;
   logic [NCH-1:0]   r_sync1;
   logic [NCH-1:0]   r_sync2;
   logic [NCH-1:0]   r_post;
   logic [NCH-1:0]   r_sticky;
   logic [CNT_W-1:0] r_cnt    [NCH];
   logic [CNT_W-1:0] r_result [NCH];

   logic [NCH-1:0]   w_edge;
   logic [NCH-1:0]   w_sat;
   logic [NCH-1:0]   w_alarm;
   logic [CNT_W-1:0] w_sum    [NCH];
   logic [CNT_W-1:0] w_value;

   assign w_edge = r_sync2 ^ r_post;

   // Two-flop synchroniser plus a post flop for edge detection
   always_ff @(posedge clkref or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_post  <= '0;
      end else begin
         r_sync1 <= toggle_in;
         r_sync2 <= r_sync1;
         r_post  <= r_sync2;
      end
   end

   // Saturating next count including this cycle's edge
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_sat[i] = w_edge[i] && (r_cnt[i] == CMAX);
         w_sum[i] = w_sat[i] ? CMAX : r_cnt[i] + CNT_W'(w_edge[i]);
      end
   end

`ifdef CLK_RATE_MON_ALARM_EN
   // Limit check on the saturated result, overflow also raises alarm
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_alarm[i] = (w_sum[i] < lo_limit) || (w_sum[i] > hi_limit) ||
                      r_sticky[i] || w_sat[i];
      end
   end
`else
   logic w_unused_lim;
   assign w_unused_lim = ^{lo_limit, hi_limit};
   assign w_alarm = '0;
`endif

   // Gate-window FSM: counting, latching and registered status outputs
   always_ff @(posedge clkref or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_wcnt   <= '0;
         r_sticky <= '0;
         update   <= 1'b0;
         ovf      <= '0;
         alarm    <= '0;
         busy     <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i]    <= '0;
            r_result[i] <= '0;
         end
      end else begin
         update <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_wcnt   <= '0;
               r_sticky <= '0;
               for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
               if (enable) begin
                  r_state <= S_RUN;
                  busy    <= 1'b1;
               end
            end
            S_RUN: begin
               if (r_wcnt == W_LAST) begin
                  r_wcnt   <= '0;
                  update   <= 1'b1;
                  ovf      <= r_sticky | w_sat;
                  alarm    <= w_alarm;
                  r_sticky <= '0;
                  for (int i = 0; i < NCH; i++) begin
                     r_result[i] <= w_sum[i];
                     r_cnt[i]    <= '0;
                  end
               end else begin
                  r_wcnt   <= r_wcnt + WC_W'(1);
                  r_sticky <= r_sticky | w_sat;
                  for (int i = 0; i < NCH; i++) r_cnt[i] <= w_sum[i];
               end
               // Abort discards the partial window; a latch already taken stands
               if (!enable) begin
                  r_state  <= S_IDLE;
                  busy     <= 1'b0;
                  r_wcnt   <= '0;
                  r_sticky <= '0;
                  for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Channel select; out-of-range selects read as zero
   always_comb begin
      w_value = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel == SEL_W'(i)) w_value = r_result[i];
      end
   end

   // Registered readout mux
   always_ff @(posedge clkref or posedge rst) begin
      if (rst) value <= '0;
      else     value <= w_value;
   end

endmodule

// File: tb/tb_clk_rate_monitor.sv
// tb_clk_rate_monitor: directed checks of gating, latching, saturation,
// abort, asynchronous reset and readout for clk_rate_monitor.
module tb_clk_rate_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] tog = '0;
   logic [3:0] sel;
   logic [7:0] lo_limit;
   logic [7:0] hi_limit;
   logic [7:0] value;
   logic       update;
   logic [3:0] ovf;
   logic [3:0] alarm;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int per  [4];
   int gcnt [4];

   clk_rate_monitor #(
      .NCH(4),
      .CLKREF_RATE_IN_MHZ(100),
      .RESULT_UNIT_HZ(100000),
      .CNT_W(8),
      .SEL_W(4)
   ) dut (
      .clkref(clk),
      .rst(rst),
      .enable(enable),
      .toggle_in(tog),
      .sel(sel),
      .lo_limit(lo_limit),
      .hi_limit(hi_limit),
      .value(value),
      .update(update),
      .ovf(ovf),
      .alarm(alarm),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Divide-by-2 toggles: flip every per[i] reference cycles, 0 = stuck
   always @(posedge clk) begin
      #1;
      if (rst) begin
         tog = '0;
         for (int i = 0; i < 4; i++) gcnt[i] = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (per[i] > 0) begin
               gcnt[i]++;
               if (gcnt[i] >= per[i]) begin
                  gcnt[i] = 0;
                  tog[i] = ~tog[i];
               end
            end
         end
      end
   end

   function automatic logic [3:0] ea(input logic [3:0] b);
`ifdef CLK_RATE_MON_ALARM_EN
      return b;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs,
                          input int lo, input int hi);
      total++;
      assert (!$isunknown(obs) && obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_upd(input int lim, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (update !== 1'b1 && n < lim);
   endtask

   int n;
   int nupd;

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      sel = 4'd0;
      lo_limit = 8'd1;
      hi_limit = 8'd254;
      per = '{4, 10, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_value", value, 0);
      chk("rst_update", update, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_busy", busy, 0);

      // steady rates
      rst = 1'b0;
      enable = 1'b1;
      wait_upd(1200, n);
      chk("first_upd_lat", n, 1001);
      chk("busy_run", busy, 1);
      chk("value_lags", value, 0);
      chk("ovf_steady", ovf, 0);
      chk("alarm_steady", alarm, ea(4'b1100));
      @(negedge clk);
      chk_rng("ch0_25mhz", value, 249, 251);
      chk("upd_one_cycle", update, 0);
      sel = 4'd1;
      @(negedge clk);
      chk_rng("ch1_10mhz", value, 99, 101);
      wait_upd(1200, n);
      chk("upd_gap", n, 998);
      @(negedge clk);
      chk_rng("ch1_win2", value, 99, 101);
      sel = 4'd2;
      @(negedge clk);
      chk("ch2_stuck", value, 0);
      sel = 4'd9;
      @(negedge clk);
      chk("sel_oob", value, 0);
      sel = 4'd0;
      @(negedge clk);
      chk_rng("sel_back0", value, 249, 251);

      // saturation on ch0
      per[0] = 2;
      wait_upd(1200, n);
      wait_upd(1200, n);
      chk("sat_gap", n, 1000);
      chk("sat_ovf", ovf, 4'b0001);
      chk("sat_alarm", alarm, ea(4'b1101));
      @(negedge clk);
      chk("sat_value", value, 255);
      per[0] = 10;
      wait_upd(1200, n);
      wait_upd(1200, n);
      chk("rec_ovf", ovf, 0);
      chk("rec_alarm", alarm, ea(4'b1100));
      @(negedge clk);
      chk_rng("rec_value", value, 99, 101);

      // abort mid-window
      sel = 4'd1;
      per[1] = 5;
      wait_upd(1200, n);
      wait_upd(1200, n);
      @(negedge clk);
      chk_rng("ch1_20mhz", value, 199, 201);
      per[1] = 10;
      repeat (498) @(negedge clk);
      enable = 1'b0;
      nupd = 0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if (update === 1'b1) nupd++;
      end
      chk("abort_no_upd", nupd, 0);
      chk("abort_idle", busy, 0);
      chk_rng("abort_keep", value, 199, 201);
      enable = 1'b1;
      wait_upd(1200, n);
      chk("reen_lat", n, 1001);
      @(negedge clk);
      chk_rng("reen_full", value, 99, 101);

      // reset mid-run
      per[3] = 2;
      wait_upd(1200, n);
      wait_upd(1200, n);
      chk("ch3_ovf", ovf, 4'b1000);
      repeat (700) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_value", value, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_alarm", alarm, 0);
      chk("arst_update", update, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_upd(1200, n);
      chk("post_rst_lat", n, 1001);
      chk("post_rst_ovf", ovf, 4'b1000);
      @(negedge clk);
      chk_rng("post_rst_ch1", value, 99, 101);
      sel = 4'd0;
      @(negedge clk);
      chk_rng("post_rst_ch0", value, 99, 101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
